// File: rtl/kp_gauss3x3.sv
// rtl/kp_gauss3x3.sv - pipelined 3x3 Gaussian blur for RGB565 with frame position markers
module kp_gauss3x3 #(
  parameter int LINE_LENGTH = 480,
  parameter int LINE_COUNT  = 480,
  parameter int DATA_WIDTH  = 16
) (
  input  logic                    i_clk,
  input  logic                    i_rstn,
  input  logic [3*DATA_WIDTH-1:0] i_r0_data,
  input  logic [3*DATA_WIDTH-1:0] i_r1_data,
  input  logic [3*DATA_WIDTH-1:0] i_r2_data,
  input  logic                    i_valid,
  input  logic                    i_bypass,
  output logic [DATA_WIDTH-1:0]   o_data,
  output logic                    o_valid,
  output logic                    o_sof,
  output logic                    o_eol,
  output logic                    o_eof
);

  // Pixel packing is fixed RGB565, so DATA_WIDTH is only meaningful at 16.
  localparam int COL_W = (LINE_LENGTH > 1) ? $clog2(LINE_LENGTH) : 1;
  localparam int ROW_W = (LINE_COUNT > 1) ? $clog2(LINE_COUNT) : 1;
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(LINE_LENGTH - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(LINE_COUNT - 1);

  // Horizontal pass over one window row: {R 7b, G 8b, B 7b} of L + 2C + R.
  function automatic logic [21:0] hsum(input logic [47:0] w);
    logic [15:0] l, c, r;
    logic [6:0]  hr, hb;
    logic [7:0]  hg;
    l  = w[47:32];
    c  = w[31:16];
    r  = w[15:0];
    hr = {2'b00, l[15:11]} + {1'b0, c[15:11], 1'b0} + {2'b00, r[15:11]};
    hg = {2'b00, l[10:5]}  + {1'b0, c[10:5], 1'b0}  + {2'b00, r[10:5]};
    hb = {2'b00, l[4:0]}   + {1'b0, c[4:0], 1'b0}   + {2'b00, r[4:0]};
    return {hr, hg, hb};
  endfunction

  // Vertical pass over the three row sums: {R 9b, G 10b, B 9b}.
  function automatic logic [27:0] vsum(input logic [21:0] h0, input logic [21:0] h1,
                                       input logic [21:0] h2);
    logic [8:0] vr, vb;
    logic [9:0] vg;
    vr = {2'b00, h0[21:15]} + {1'b0, h1[21:15], 1'b0} + {2'b00, h2[21:15]};
    vg = {2'b00, h0[14:7]}  + {1'b0, h1[14:7], 1'b0}  + {2'b00, h2[14:7]};
    vb = {2'b00, h0[6:0]}   + {1'b0, h1[6:0], 1'b0}   + {2'b00, h2[6:0]};
    return {vr, vg, vb};
  endfunction

  // Divide by 16 with round-half-up; kernel weights sum to 16 so no channel can overflow.
  function automatic logic [15:0] round_pack(input logic [27:0] v);
    return {5'((v[27:19] + 9'd8) >> 4), 6'((v[18:9] + 10'd8) >> 4), 5'((v[8:0] + 9'd8) >> 4)};
  endfunction

  logic [2:0]       vld_sr;
  logic [21:0]      s1_h0, s1_h1, s1_h2;
  logic             s1_byp;
  logic [15:0]      s1_ctr;
  logic [27:0]      s2_v;
  logic             s2_byp;
  logic [15:0]      s2_ctr;
  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;

  assign o_valid = vld_sr[2];

  // Valid bits walk alongside the data; no backpressure, so they always shift.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      vld_sr <= '0;
    end else begin
      vld_sr <= {vld_sr[1:0], i_valid};
    end
  end

  // Stage 1: horizontal sums, plus the bypass bit and centre pixel carried alongside.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      s1_h0  <= '0;
      s1_h1  <= '0;
      s1_h2  <= '0;
      s1_byp <= 1'b0;
      s1_ctr <= '0;
    end else if (i_valid) begin
      s1_h0  <= hsum(i_r0_data);
      s1_h1  <= hsum(i_r1_data);
      s1_h2  <= hsum(i_r2_data);
      s1_byp <= i_bypass;
      s1_ctr <= i_r1_data[31:16];
    end
  end

  // Stage 2: vertical weighted sum of the three row results.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      s2_v   <= '0;
      s2_byp <= 1'b0;
      s2_ctr <= '0;
    end else if (vld_sr[0]) begin
      s2_v   <= vsum(s1_h0, s1_h1, s1_h2);
      s2_byp <= s1_byp;
      s2_ctr <= s1_ctr;
    end
  end

  // Stage 3: normalise and pack, or forward the untouched centre pixel when bypassed.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      o_data <= '0;
    end else if (vld_sr[1]) begin
      o_data <= s2_byp ? s2_ctr : round_pack(s2_v);
    end
  end

  // Position tracking: markers come from the count before it advances for this pixel.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      col   <= '0;
      row   <= '0;
      o_sof <= 1'b0;
      o_eol <= 1'b0;
      o_eof <= 1'b0;
    end else if (vld_sr[1]) begin
      o_sof <= (col == '0) && (row == '0);
      o_eol <= (col == COL_LAST);
      o_eof <= (col == COL_LAST) && (row == ROW_LAST);
      if (col == COL_LAST) begin
        col <= '0;
        row <= (row == ROW_LAST) ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end else begin
      o_sof <= 1'b0;
      o_eol <= 1'b0;
      o_eof <= 1'b0;
    end
  end

endmodule

// File: tb/tb_kp_gauss3x3.sv
// tb/tb_kp_gauss3x3.sv - scoreboard bench for kp_gauss3x3 with directed vectors
module tb_kp_gauss3x3;

  localparam int LL    = 4;
  localparam int LC    = 2;
  localparam int FRAME = LL * LC;

  logic        clk;
  logic        rstn;
  logic [47:0] r0, r1, r2;
  logic        vin, byp;
  logic [15:0] o_data;
  logic        o_valid, o_sof, o_eol, o_eof;

  typedef struct {
    logic [15:0] data;
    logic        sof;
    logic        eol;
    logic        eof;
    int          cyc;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   pix = 0;

  logic [47:0] tab_r0 [4];
  logic [47:0] tab_r1 [4];
  logic [47:0] tab_r2 [4];
  logic [15:0] tab_e  [4];

  kp_gauss3x3 #(.LINE_LENGTH(LL), .LINE_COUNT(LC), .DATA_WIDTH(16)) dut (
    .i_clk(clk), .i_rstn(rstn),
    .i_r0_data(r0), .i_r1_data(r1), .i_r2_data(r2),
    .i_valid(vin), .i_bypass(byp),
    .o_data(o_data), .o_valid(o_valid),
    .o_sof(o_sof), .o_eol(o_eol), .o_eof(o_eof)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] r16();
    return 16'($urandom());
  endfunction

  function automatic logic [47:0] r48();
    return {r16(), r16(), r16()};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Present one window and queue its expected pixel with model-derived markers.
  task automatic send(input logic [47:0] a, input logic [47:0] b, input logic [47:0] c,
                      input logic bp, input logic [15:0] e);
    exp_t x;
    @(posedge clk); #1;
    r0 = a; r1 = b; r2 = c; byp = bp; vin = 1'b1;
    x.data = e;
    x.sof  = (pix % FRAME) == 0;
    x.eol  = (pix % LL) == LL - 1;
    x.eof  = (pix % FRAME) == FRAME - 1;
    x.cyc  = cyc;
    q.push_back(x);
    pix++;
  endtask

  // Idle cycles carry junk data and bypass=1, all of which must be ignored.
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      vin = 1'b0; byp = 1'b1; r0 = r48(); r1 = r48(); r2 = r48();
    end
  endtask

  initial begin
    exp_t e;
    rstn = 1'b0; vin = 1'b0; byp = 1'b0; r0 = '0; r1 = '0; r2 = '0;

    tab_r0[0] = {3{16'h7BEF}};     tab_r1[0] = {3{16'h7BEF}};            tab_r2[0] = {3{16'h7BEF}};     tab_e[0] = 16'h7BEF;
    tab_r0[1] = '0;                tab_r1[1] = {16'h0, 16'hFFFF, 16'h0}; tab_r2[1] = '0;                tab_e[1] = 16'h4208;
    tab_r0[2] = {16'h0800, 32'h0}; tab_r1[2] = '0;                       tab_r2[2] = '0;                tab_e[2] = 16'h0000;
    tab_r0[3] = {3{16'hFFFF}};     tab_r1[3] = {3{16'hFFFF}};            tab_r2[3] = {3{16'hFFFF}};     tab_e[3] = 16'hFFFF;

    fork
      forever begin
        @(negedge clk);
        if (rstn) begin
          if (o_valid) begin
            if (q.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL unexpected_output: got data %h with nothing pending, required no output", o_data);
            end else begin
              e = q.pop_front();
              check("data", 32'(o_data), 32'(e.data));
              check("sof", 32'(o_sof), 32'(e.sof));
              check("eol", 32'(o_eol), 32'(e.eol));
              check("eof", 32'(o_eof), 32'(e.eof));
              check("latency", 32'(cyc - e.cyc), 32'd3);
            end
          end else begin
            check("idle_markers", {29'd0, o_sof, o_eol, o_eof}, 32'd0);
          end
        end
      end
    join_none

    #3;
    check("rst_data", 32'(o_data), 32'd0);
    check("rst_ctrl", {28'd0, o_valid, o_sof, o_eol, o_eof}, 32'd0);
    repeat (2) @(posedge clk);
    #2 rstn = 1'b1;

    // First frame: constant field, impulse, rounding edges, saturation-free all-ones.
    repeat (5) send(tab_r0[0], tab_r1[0], tab_r2[0], 1'b0, 16'h7BEF);
    idle(2);
    send(tab_r0[1], tab_r1[1], tab_r2[1], 1'b0, 16'h4208);
    idle($urandom_range(0, 3));
    send(tab_r0[2], tab_r1[2], tab_r2[2], 1'b0, 16'h0000);
    send('0, {16'h0, 16'h1000, 16'h0}, '0, 1'b0, 16'h0800);
    idle(1);
    send(tab_r0[3], tab_r1[3], tab_r2[3], 1'b0, 16'hFFFF);

    // Bypass forwards the centre; the same centre unbypassed is filtered.
    send(r48(), {r16(), 16'h1234, r16()}, r48(), 1'b1, 16'h1234);
    send('0, {16'h0, 16'h1234, 16'h0}, '0, 1'b0, 16'h0885);
    idle(3);
    send(tab_r0[1], tab_r1[1], tab_r2[1], 1'b0, 16'h4208);

    // Random gaps across several frame wraps.
    for (int i = 0; i < 16; i++) begin
      idle($urandom_range(0, 2));
      send(tab_r0[i % 4], tab_r1[i % 4], tab_r2[i % 4], 1'b0, tab_e[i % 4]);
    end
    idle(6);

    // Reset with two pixels in flight after five outputs.
    repeat (7) send(tab_r0[3], tab_r1[3], tab_r2[3], 1'b0, 16'hFFFF);
    @(posedge clk); #1;
    vin = 1'b0;
    @(negedge clk); #1;
    check("inflight_count", 32'(q.size()), 32'd2);
    rstn = 1'b0;
    #1;
    check("midrst_data", 32'(o_data), 32'd0);
    check("midrst_ctrl", {28'd0, o_valid, o_sof, o_eol, o_eof}, 32'd0);
    q.delete();
    pix = 0;
    repeat (2) @(posedge clk);
    #2 rstn = 1'b1;
    idle(5);
    send(tab_r0[1], tab_r1[1], tab_r2[1], 1'b0, 16'h4208);
    send(tab_r0[0], tab_r1[0], tab_r2[0], 1'b0, 16'h7BEF);
    idle(1);

    for (int i = 0; i < 20 && q.size() != 0; i++) @(posedge clk);
    @(negedge clk); #1;
    check("drain_pending", 32'(q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
